cpu_axi_bridge: RTL and testbench
=================================

# cpu_axi_bridge

Blocking bridge between the core's SRAM-style instruction/data ports and a single-beat AXI master subset. Sits directly downstream of the core's `inst_sram_*`/`data_sram_*` outputs and upstream of the system interconnect. Serializes requests, one outstanding transaction at a time, data before instruction. Freezes the whole pipeline through `stallreq_from_bus` into CTRL until every request of the current cycle has completed.

## Interface
- No parameters. All AXI IDs are 0; len=0, size=2, burst=INCR. Lock, cache and prot are tied off outside this block.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_sram_en` in 1: instruction fetch request.
- `inst_sram_addr` in 32: fetch address, word aligned.
- `inst_sram_rdata` out 32: fetched word, registered.
- `data_sram_en` in 1: data access request.
- `data_sram_wen` in 4: byte strobes; 0 means load.
- `data_sram_addr` in 32: data address.
- `data_sram_wdata` in 32: store data.
- `data_sram_rdata` out 32: loaded word, registered.
- `stallreq_from_bus` out 1: freeze request to CTRL.
- `araddr` out 32, `arvalid` out 1, `arready` in 1: read address channel.
- `rdata` in 32, `rvalid` in 1, `rready` out 1: read data channel.
- `awaddr` out 32, `awvalid` out 1, `awready` in 1: write address channel.
- `wdata` out 32, `wstrb` out 4, `wvalid` out 1, `wready` in 1: write data channel; `wlast` is tied to 1.
- `bvalid` in 1, `bready` out 1: write response channel.

## Operation
- FSM states: IDLE, D_AR, D_R, D_W, D_B, I_AR, I_R, DONE.
- **IDLE**
  - If `data_sram_en`: go to D_W when `wen`≠0, otherwise D_AR.
  - Else if `inst_sram_en`: go to I_AR.
  - Latch `i_pend` = `inst_sram_en` on entry to any non-IDLE state.
- **D_AR**: `arvalid`=1, `araddr`=`data_sram_addr`. On `arready`, go to D_R.
- **D_R**: `rready`=1. On `rvalid`, `data_sram_rdata` ← `rdata`; go to I_AR if `i_pend`, else DONE.
- **D_W**
  - `awvalid` and `wvalid` are raised together; `wstrb`=`wen`.
  - Each handshake is tracked separately by flags `aw_ok` and `w_ok`; the valid for a channel drops once its flag is set.
  - When both flags are set, go to D_B.
- **D_B**: `bready`=1. On `bvalid`, go to I_AR if `i_pend`, else DONE.
- **I_AR / I_R**: same as D_AR / D_R using `inst_sram_addr`, writing `inst_sram_rdata`. Exit to DONE.
- **DONE**: go to IDLE after one cycle; clear `i_pend`, `aw_ok` and `w_ok`.
- **Stall**: `stallreq_from_bus` = (IDLE & (`inst_sram_en` | `data_sram_en`)) | (state ∉ {IDLE, DONE}). It is combinational from the IDLE inputs.
- The core holds its request inputs stable while stalled. The bridge uses the live core inputs and does not re-capture addresses.

## Timing
- Reset values:
  - state IDLE.
  - All valid/ready outputs 0.
  - Both rdata outputs 0.
  - `stallreq_from_bus` 0 whenever the core request inputs are 0.
- A reset mid-transaction abandons it with no completion; the interconnect must be reset in the same cycle.
- Minimum load latency with zero-wait slave: request cycle N, D_AR at N+1, D_R at N+2, DONE at N+3.
  - Stall is high during N..N+2 and low in DONE.
  - `rdata` is valid from DONE until the next capture.
- A data and an instruction request in the same cycle are served data first; stall stays high until the instruction read completes.
- AW and W may complete in either order or the same cycle.
- `bvalid`/`rvalid` arriving in a state that does not expect them is ignored.
- At most one AXI transaction is outstanding.

## Structure
- Shared package (defines file): FSM state encodings, the tie-off constants (id, len, size, burst), and a `BusStall` width macro.
- No sub-modules. CTRL gains a `stallreq_from_bus` input.

## Test plan
- **Load, zero-wait slave**: load addr 0x1000, slave returns 0xDEADBEEF → stall high 3 cycles, `data_sram_rdata`=0xDEADBEEF in DONE.
- **Store with split handshakes**: `wen`=0x3, `wdata`=0x1234ABCD, `awready` 2 cycles before `wready` → `wstrb`=0x3, `bready` only after both handshakes, stall drops on DONE.
- **Simultaneous requests**: fetch 0xBFC00000 plus load 0x2000 in the same cycle → AR order 0x2000 then 0xBFC00000; single DONE; both rdata outputs correct.
- **Backpressure**: `arready` low 5 cycles → `arvalid` and `araddr` held stable, stall high throughout.
- **Reset mid-transaction**: `rst` during D_R → next cycle IDLE, all valids 0, rdata outputs 0, no stall.
- **Back-to-back fetches**: idle cycles between transactions equal exactly 1 DONE plus 1 IDLE.

Source files
------------

// File: rtl/cpu_axi_bridge_pkg.sv
// cpu_axi_bridge_pkg: shared types and constants for the SRAM-to-AXI bridge.
//   - Bus widths and the stall request width.
//   - Fixed AXI single-beat attributes (id, len, size, burst).
//   - FSM state encoding and a helper that marks the states holding the pipeline.
package cpu_axi_bridge_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned STRB_W      = 4;
  localparam int unsigned ID_W        = 4;
  localparam int unsigned LEN_W       = 8;
  localparam int unsigned SIZE_W      = 3;
  localparam int unsigned BURST_W     = 2;
  localparam int unsigned BUS_STALL_W = 1;

  // Single-beat, 4-byte, INCR transfers with ID 0
  localparam logic [ID_W-1:0]    AXI_ID    = ID_W'(0);
  localparam logic [LEN_W-1:0]   AXI_LEN   = LEN_W'(0);
  localparam logic [SIZE_W-1:0]  AXI_SIZE  = SIZE_W'(2);
  localparam logic [BURST_W-1:0] AXI_BURST = BURST_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_D_AR = 3'd1,
    ST_D_R  = 3'd2,
    ST_D_W  = 3'd3,
    ST_D_B  = 3'd4,
    ST_I_AR = 3'd5,
    ST_I_R  = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  // A transaction is in flight in every state except IDLE and DONE
  function automatic logic is_busy(input state_e s);
    return (s != ST_IDLE) && (s != ST_DONE);
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// cpu_axi_bridge_if: single-beat AXI master subset used by the bridge.
//   master modport: bridge side (drives AR/AW/W valids, R/B readies).
//   slave  modport: interconnect side.
interface cpu_axi_bridge_if;
  import cpu_axi_bridge_pkg::*;

  logic [ID_W-1:0]    arid;
  logic [ADDR_W-1:0]  araddr;
  logic [LEN_W-1:0]   arlen;
  logic [SIZE_W-1:0]  arsize;
  logic [BURST_W-1:0] arburst;
  logic               arvalid;
  logic               arready;

  logic [DATA_W-1:0]  rdata;
  logic               rvalid;
  logic               rready;

  logic [ID_W-1:0]    awid;
  logic [ADDR_W-1:0]  awaddr;
  logic [LEN_W-1:0]   awlen;
  logic [SIZE_W-1:0]  awsize;
  logic [BURST_W-1:0] awburst;
  logic               awvalid;
  logic               awready;

  logic [DATA_W-1:0]  wdata;
  logic [STRB_W-1:0]  wstrb;
  logic               wlast;
  logic               wvalid;
  logic               wready;

  logic               bvalid;
  logic               bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rdata, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bvalid, output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rdata, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bvalid, input bready
  );

endinterface

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: blocking bridge from the core's SRAM-style fetch/data ports to
// a single-beat AXI master. One transaction outstanding, data before fetch; the
// pipeline is frozen via stallreq_from_bus until the cycle's requests complete.
//   clk, rst            : clock, synchronous active-high reset
//   inst_sram_*         : fetch request and registered fetched word
//   data_sram_*         : load/store request and registered loaded word
//   stallreq_from_bus   : freeze request to CTRL (combinational from IDLE inputs)
//   axi                 : AXI master port
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inst_sram_en,
  input  logic [ADDR_W-1:0]      inst_sram_addr,
  output logic [DATA_W-1:0]      inst_sram_rdata,
  input  logic                   data_sram_en,
  input  logic [STRB_W-1:0]      data_sram_wen,
  input  logic [ADDR_W-1:0]      data_sram_addr,
  input  logic [DATA_W-1:0]      data_sram_wdata,
  output logic [DATA_W-1:0]      data_sram_rdata,
  output logic [BUS_STALL_W-1:0] stallreq_from_bus,
  cpu_axi_bridge_if.master       axi
);

  state_e              state_q, state_d;
  logic                i_pend_q, i_pend_d;
  logic                aw_ok_q, aw_ok_d;
  logic                w_ok_q, w_ok_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

  logic                arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic [ADDR_W-1:0]   araddr_q, awaddr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;

  // Next-state and capture logic
  always_comb begin
    state_d      = state_q;
    i_pend_d     = i_pend_q;
    aw_ok_d      = aw_ok_q;
    w_ok_d       = w_ok_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (data_sram_en) begin
          state_d  = (data_sram_wen != '0) ? ST_D_W : ST_D_AR;
          i_pend_d = inst_sram_en;
        end else if (inst_sram_en) begin
          state_d  = ST_I_AR;
          i_pend_d = 1'b1;
        end
      end
      ST_D_AR: if (arvalid_q && axi.arready) state_d = ST_D_R;
      ST_D_R: begin
        if (rready_q && axi.rvalid) begin
          data_rdata_d = axi.rdata;
          state_d      = i_pend_q ? ST_I_AR : ST_DONE;
        end
      end
      ST_D_W: begin
        // AW and W may complete in either order or together
        aw_ok_d = aw_ok_q | (awvalid_q & axi.awready);
        w_ok_d  = w_ok_q  | (wvalid_q  & axi.wready);
        if (aw_ok_d && w_ok_d) state_d = ST_D_B;
      end
      ST_D_B: if (bready_q && axi.bvalid) state_d = i_pend_q ? ST_I_AR : ST_DONE;
      ST_I_AR: if (arvalid_q && axi.arready) state_d = ST_I_R;
      ST_I_R: begin
        if (rready_q && axi.rvalid) begin
          inst_rdata_d = axi.rdata;
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        i_pend_d = 1'b0;
        aw_ok_d  = 1'b0;
        w_ok_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, flags and registered AXI outputs (decoded from the next state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      i_pend_q     <= 1'b0;
      aw_ok_q      <= 1'b0;
      w_ok_q       <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      araddr_q     <= '0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      i_pend_q     <= i_pend_d;
      aw_ok_q      <= aw_ok_d;
      w_ok_q       <= w_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      arvalid_q    <= (state_d == ST_D_AR) || (state_d == ST_I_AR);
      rready_q     <= (state_d == ST_D_R)  || (state_d == ST_I_R);
      awvalid_q    <= (state_d == ST_D_W) && !aw_ok_d;
      wvalid_q     <= (state_d == ST_D_W) && !w_ok_d;
      bready_q     <= (state_d == ST_D_B);
      // Addresses follow the live core inputs, which are held while stalled
      if (state_d == ST_D_AR) araddr_q <= data_sram_addr;
      if (state_d == ST_I_AR) araddr_q <= inst_sram_addr;
      if (state_d == ST_D_W) begin
        awaddr_q <= data_sram_addr;
        wdata_q  <= data_sram_wdata;
        wstrb_q  <= data_sram_wen;
      end
    end
  end

  assign stallreq_from_bus = BUS_STALL_W'(((state_q == ST_IDLE) && (inst_sram_en || data_sram_en))
                                          || is_busy(state_q));

  assign inst_sram_rdata = inst_rdata_q;
  assign data_sram_rdata = data_rdata_q;

  assign axi.arid    = AXI_ID;
  assign axi.arlen   = AXI_LEN;
  assign axi.arsize  = AXI_SIZE;
  assign axi.arburst = AXI_BURST;
  assign axi.araddr  = araddr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awid    = AXI_ID;
  assign axi.awlen   = AXI_LEN;
  assign axi.awsize  = AXI_SIZE;
  assign axi.awburst = AXI_BURST;
  assign axi.awaddr  = awaddr_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// tb_cpu_axi_bridge: directed bench for cpu_axi_bridge. The AXI slave is driven
// step by step; outputs are sampled 1 time unit after each rising edge.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [0:0]  stallreq_from_bus;

  int checks = 0;
  int errors = 0;

  cpu_axi_bridge_if axi ();

  cpu_axi_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .inst_sram_en      (inst_sram_en),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_en      (data_sram_en),
    .data_sram_wen     (data_sram_wen),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_rdata   (data_sram_rdata),
    .stallreq_from_bus (stallreq_from_bus),
    .axi               (axi)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, " arvalid"}, 32'(axi.arvalid), 32'd0);
    chk({tag, " rready"},  32'(axi.rready),  32'd0);
    chk({tag, " awvalid"}, 32'(axi.awvalid), 32'd0);
    chk({tag, " wvalid"},  32'(axi.wvalid),  32'd0);
    chk({tag, " bready"},  32'(axi.bready),  32'd0);
  endtask

  initial begin
    rst = 1'b1;
    inst_sram_en = 1'b0; inst_sram_addr = '0;
    data_sram_en = 1'b0; data_sram_wen = '0; data_sram_addr = '0; data_sram_wdata = '0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    chk_idle_outs("rst");
    chk("rst inst_rdata", inst_sram_rdata, 32'h0);
    chk("rst data_rdata", data_sram_rdata, 32'h0);
    chk("rst stall", 32'(stallreq_from_bus), 32'd0);
    chk("tie arlen", 32'(axi.arlen), 32'd0);
    chk("tie arsize", 32'(axi.arsize), 32'd2);
    chk("tie arburst", 32'(axi.arburst), 32'd1);
    chk("tie wlast", 32'(axi.wlast), 32'd1);

    // Load, zero-wait slave
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h0000_1000;
    axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata = 32'hDEAD_BEEF;
    #1 chk("ld N stall", 32'(stallreq_from_bus), 32'd1);
    step();
    chk("ld N+1 stall", 32'(stallreq_from_bus), 32'd1);
    chk("ld arvalid", 32'(axi.arvalid), 32'd1);
    chk("ld araddr", axi.araddr, 32'h0000_1000);
    step();
    chk("ld N+2 stall", 32'(stallreq_from_bus), 32'd1);
    chk("ld rready", 32'(axi.rready), 32'd1);
    chk("ld arvalid drop", 32'(axi.arvalid), 32'd0);
    step();
    chk("ld done stall", 32'(stallreq_from_bus), 32'd0);
    chk("ld rdata", data_sram_rdata, 32'hDEAD_BEEF);
    chk("ld rready drop", 32'(axi.rready), 32'd0);
    data_sram_en = 1'b0; axi.arready = 1'b0; axi.rvalid = 1'b0;
    step();
    chk("ld idle stall", 32'(stallreq_from_bus), 32'd0);

    // Store, AW accepted two cycles before W
    data_sram_en = 1'b1; data_sram_wen = 4'h3; data_sram_addr = 32'h0000_3000;
    data_sram_wdata = 32'h1234_ABCD; axi.awready = 1'b1; axi.wready = 1'b0;
    step();
    chk("st awvalid", 32'(axi.awvalid), 32'd1);
    chk("st wvalid", 32'(axi.wvalid), 32'd1);
    chk("st wstrb", 32'(axi.wstrb), 32'h3);
    chk("st wdata", axi.wdata, 32'h1234_ABCD);
    chk("st awaddr", axi.awaddr, 32'h0000_3000);
    step();
    axi.awready = 1'b0;
    chk("st awvalid drop", 32'(axi.awvalid), 32'd0);
    chk("st wvalid held", 32'(axi.wvalid), 32'd1);
    chk("st bready early1", 32'(axi.bready), 32'd0);
    step();
    chk("st bready early2", 32'(axi.bready), 32'd0);
    axi.wready = 1'b1;
    step();
    axi.wready = 1'b0; axi.bvalid = 1'b1;
    chk("st bready", 32'(axi.bready), 32'd1);
    chk("st wvalid drop", 32'(axi.wvalid), 32'd0);
    chk("st b stall", 32'(stallreq_from_bus), 32'd1);
    step();
    chk("st done stall", 32'(stallreq_from_bus), 32'd0);
    chk("st bready drop", 32'(axi.bready), 32'd0);
    data_sram_en = 1'b0; data_sram_wen = 4'h0; axi.bvalid = 1'b0;
    step();

    // Simultaneous load and fetch: data read first
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0000;
    data_sram_en = 1'b1; data_sram_addr = 32'h0000_2000; axi.arready = 1'b1;
    step();
    chk("sim ar1 addr", axi.araddr, 32'h0000_2000);
    chk("sim ar1 valid", 32'(axi.arvalid), 32'd1);
    step();
    axi.rvalid = 1'b1; axi.rdata = 32'h1111_2222;
    chk("sim dr stall", 32'(stallreq_from_bus), 32'd1);
    step();
    axi.rvalid = 1'b0; axi.rdata = 32'h3333_4444;
    chk("sim ar2 addr", axi.araddr, 32'hBFC0_0000);
    chk("sim ar2 valid", 32'(axi.arvalid), 32'd1);
    chk("sim ar2 stall", 32'(stallreq_from_bus), 32'd1);
    chk("sim data rdata", data_sram_rdata, 32'h1111_2222);
    step();
    axi.rvalid = 1'b1;
    chk("sim ir rready", 32'(axi.rready), 32'd1);
    chk("sim ir stall", 32'(stallreq_from_bus), 32'd1);
    step();
    chk("sim done stall", 32'(stallreq_from_bus), 32'd0);
    chk("sim inst rdata", inst_sram_rdata, 32'h3333_4444);
    chk("sim data kept", data_sram_rdata, 32'h1111_2222);
    inst_sram_en = 1'b0; data_sram_en = 1'b0; axi.rvalid = 1'b0; axi.arready = 1'b0;
    step();
    chk("sim idle arvalid", 32'(axi.arvalid), 32'd0);
    chk("sim idle stall", 32'(stallreq_from_bus), 32'd0);

    // AR backpressure
    data_sram_en = 1'b1; data_sram_addr = 32'h0000_4000;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp arvalid", 32'(axi.arvalid), 32'd1);
      chk("bp araddr", axi.araddr, 32'h0000_4000);
      chk("bp stall", 32'(stallreq_from_bus), 32'd1);
      step();
    end
    chk("bp arvalid end", 32'(axi.arvalid), 32'd1);
    axi.arready = 1'b1;
    step();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'hCAFE_F00D;
    chk("bp rready", 32'(axi.rready), 32'd1);
    step();
    chk("bp rdata", data_sram_rdata, 32'hCAFE_F00D);
    data_sram_en = 1'b0; axi.rvalid = 1'b0;
    step();

    // Reset during D_R
    data_sram_en = 1'b1; data_sram_addr = 32'h0000_5000; axi.arready = 1'b1;
    step();
    step();
    chk("mr rready", 32'(axi.rready), 32'd1);
    rst = 1'b1; data_sram_en = 1'b0; axi.arready = 1'b0;
    step();
    rst = 1'b0;
    chk_idle_outs("mr");
    chk("mr data rdata", data_sram_rdata, 32'h0);
    chk("mr inst rdata", inst_sram_rdata, 32'h0);
    chk("mr stall", 32'(stallreq_from_bus), 32'd0);
    step();
    chk("mr idle arvalid", 32'(axi.arvalid), 32'd0);

    // Back-to-back fetches: DONE + IDLE between transactions
    inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0004;
    axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata = 32'hAAAA_0001;
    step();
    chk("bb ar1", axi.araddr, 32'hBFC0_0004);
    chk("bb ar1 valid", 32'(axi.arvalid), 32'd1);
    step();
    chk("bb r1 rready", 32'(axi.rready), 32'd1);
    step();
    chk("bb done rdata", inst_sram_rdata, 32'hAAAA_0001);
    chk("bb done arvalid", 32'(axi.arvalid), 32'd0);
    chk("bb done stall", 32'(stallreq_from_bus), 32'd0);
    inst_sram_addr = 32'hBFC0_0008; axi.rdata = 32'hAAAA_0002;
    step();
    chk("bb idle arvalid", 32'(axi.arvalid), 32'd0);
    chk("bb idle stall", 32'(stallreq_from_bus), 32'd1);
    step();
    chk("bb ar2", axi.araddr, 32'hBFC0_0008);
    chk("bb ar2 valid", 32'(axi.arvalid), 32'd1);
    step();
    step();
    chk("bb done2 rdata", inst_sram_rdata, 32'hAAAA_0002);
    inst_sram_en = 1'b0; axi.arready = 1'b0; axi.rvalid = 1'b0;
    step();

    // Store + fetch; AW/W together; early bvalid ignored until D_B
    data_sram_en = 1'b1; data_sram_wen = 4'hF; data_sram_addr = 32'h0000_6000;
    data_sram_wdata = 32'h55AA_55AA; inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0010;
    axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b1;
    step();
    chk("sf wstrb", 32'(axi.wstrb), 32'hF);
    chk("sf bready w", 32'(axi.bready), 32'd0);
    step();
    chk("sf bready", 32'(axi.bready), 32'd1);
    chk("sf awvalid drop", 32'(axi.awvalid), 32'd0);
    chk("sf wvalid drop", 32'(axi.wvalid), 32'd0);
    axi.awready = 1'b0; axi.wready = 1'b0;
    step();
    axi.bvalid = 1'b0; axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rdata = 32'h7777_8888;
    chk("sf ar addr", axi.araddr, 32'hBFC0_0010);
    chk("sf ar stall", 32'(stallreq_from_bus), 32'd1);
    step();
    step();
    chk("sf inst rdata", inst_sram_rdata, 32'h7777_8888);
    chk("sf done stall", 32'(stallreq_from_bus), 32'd0);
    data_sram_en = 1'b0; inst_sram_en = 1'b0; axi.arready = 1'b0; axi.rvalid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
